// File: rtl/blaster_pkg.sv
// ---------------------------------------------------------------------------
// blaster_pkg
// Shared definitions for the USB-Blaster style host encoder: the bit masks of
// the encoded command byte, the encoder FSM state type, shift/pending limits
// and small helpers that build bit-bang and shift-header bytes.
// ---------------------------------------------------------------------------
package blaster_pkg;

   // Bit positions inside an encoded command byte.
   localparam logic [7:0] MASK_TCK   = 8'h01;
   localparam logic [7:0] MASK_TMS   = 8'h02;
   localparam logic [7:0] MASK_TDI   = 8'h10;
   localparam logic [7:0] MASK_LED   = 8'h20;
   localparam logic [7:0] MASK_READ  = 8'h40;
   localparam logic [7:0] MASK_SHIFT = 8'h80;

   // Largest payload a single shift header can announce (6-bit length field).
   localparam int MAX_SHIFT_LEN = 63;
   localparam int LEN_W         = $clog2(MAX_SHIFT_LEN + 1);

   // Outstanding-response counter width, and the level above which new
   // commands are held off so one more full read-shift cannot overflow it.
   localparam int              PENDING_W          = 8;
   localparam logic [PENDING_W-1:0] PENDING_ACCEPT_MAX = 8'd192;

   typedef enum logic [2:0] {
      IDLE,
      BB_LOW,
      BB_HIGH,
      SH_HDR,
      SH_DATA
   } state_t;

   // Bit-bang byte from individual pin levels.
   function automatic logic [7:0] bb_byte(input logic tms, input logic tdi,
                                          input logic led, input logic tck,
                                          input logic rd);
      logic [7:0] b;
      b = 8'h00;
      if (tck) b = b | MASK_TCK;
      if (tms) b = b | MASK_TMS;
      if (tdi) b = b | MASK_TDI;
      if (led) b = b | MASK_LED;
      if (rd)  b = b | MASK_READ;
      return b;
   endfunction

   // Shift header: SHIFT flag, optional READ flag, payload length in [5:0].
   function automatic logic [7:0] shift_hdr(input logic rd, input logic [LEN_W-1:0] len);
      logic [7:0] b;
      b = MASK_SHIFT | {{(8-LEN_W){1'b0}}, len};
      if (rd) b = b | MASK_READ;
      return b;
   endfunction

endpackage

// File: rtl/blaster_resp_tracker.sv
// ---------------------------------------------------------------------------
// blaster_resp_tracker
// Counts responses owed by the adapter, pairs incoming RX bytes with them,
// flags stray bytes and gives up on a silent adapter after TIMEOUT_CYCLES.
//
// Ports
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_inc             a readback-generating byte was handed to the TX FIFO
//   i_rx_valid/_byte  response byte from the UART receiver (no backpressure)
//   o_pending         number of responses still owed
//   o_rd_valid/_byte  matched response, one-cycle strobe
//   o_unexpected      one-cycle pulse: RX byte arrived with nothing owed
//   o_timeout         one-cycle pulse: window expired, o_pending cleared
// ---------------------------------------------------------------------------
module blaster_resp_tracker
   import blaster_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_inc,
   input  logic                 i_rx_valid,
   input  logic [7:0]           i_rx_byte,
   output logic [PENDING_W-1:0] o_pending,
   output logic                 o_rd_valid,
   output logic [7:0]           o_rd_byte,
   output logic                 o_unexpected,
   output logic                 o_timeout
);

   logic [PENDING_W-1:0] pending_q, pending_d;
   logic [23:0]          tmo_cnt_q, tmo_cnt_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [7:0]           rd_byte_q, rd_byte_d;
   logic                 unexpected_q, unexpected_d;
   logic                 timeout_q, timeout_d;
   logic                 matched;

   // A byte counts as a real response if something is owed, or if the very
   // request it answers is being counted in this same cycle.
   assign matched = i_rx_valid && ((pending_q != '0) || i_inc);

   always_comb begin
      pending_d    = pending_q;
      tmo_cnt_d    = tmo_cnt_q;
      timeout_d    = 1'b0;
      rd_valid_d   = matched;
      rd_byte_d    = matched ? i_rx_byte : rd_byte_q;
      unexpected_d = i_rx_valid && !matched;

      case ({i_inc, matched})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase

      // Window restarts on every response and is idle while nothing is owed.
      if (i_rx_valid || (pending_q == '0)) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q >= TIMEOUT_CYCLES - 24'd1) begin
         timeout_d = 1'b1;
         tmo_cnt_d = '0;
         // Owed responses are written off; a request leaving this very cycle
         // is still owed.
         pending_d = i_inc ? PENDING_W'(1) : '0;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 24'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pending_q    <= '0;
         tmo_cnt_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_byte_q    <= '0;
         unexpected_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         tmo_cnt_q    <= tmo_cnt_d;
         rd_valid_q   <= rd_valid_d;
         rd_byte_q    <= rd_byte_d;
         unexpected_q <= unexpected_d;
         timeout_q    <= timeout_d;
      end
   end

   assign o_pending    = pending_q;
   assign o_rd_valid   = rd_valid_q;
   assign o_rd_byte    = rd_byte_q;
   assign o_unexpected = unexpected_q;
   assign o_timeout    = timeout_q;

endmodule

// File: rtl/blaster_host_encoder.sv
// ---------------------------------------------------------------------------
// blaster_host_encoder
// Turns JTAG bit-bang and byte-shift commands into the USB-Blaster byte
// protocol for a UART TX FIFO, and routes adapter responses back as readback
// bytes.  A bit-bang command emits two bytes (TCK low, then TCK high); a
// shift command emits a header byte followed by len payload bytes.
//
// Ports
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready      command handshake
//   i_cmd_shift, i_cmd_read      shift command / request readback
//   i_cmd_tms/_tdi/_led          pin levels for a bit-bang step
//   i_cmd_len                    shift payload length (0 = discard command)
//   i_data_valid/o_data_ready    shift payload byte handshake, i_data
//   o_tx_valid/i_tx_ready        encoded byte stream, o_tx_byte
//   i_rx_valid, i_rx_byte        adapter responses
//   o_rd_valid, o_rd_byte        readback bytes (one-cycle strobe)
//   o_pending                    responses still owed
//   o_busy                       command in progress or byte not yet taken
//   o_unexpected, o_timeout      stray-byte / response-timeout pulses
// ---------------------------------------------------------------------------
module blaster_host_encoder
   import blaster_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_shift,
   input  logic                 i_cmd_read,
   input  logic                 i_cmd_tms,
   input  logic                 i_cmd_tdi,
   input  logic                 i_cmd_led,
   input  logic [5:0]           i_cmd_len,
   input  logic                 i_data_valid,
   output logic                 o_data_ready,
   input  logic [7:0]           i_data,
   output logic                 o_tx_valid,
   input  logic                 i_tx_ready,
   output logic [7:0]           o_tx_byte,
   input  logic                 i_rx_valid,
   input  logic [7:0]           i_rx_byte,
   output logic                 o_rd_valid,
   output logic [7:0]           o_rd_byte,
   output logic [PENDING_W-1:0] o_pending,
   output logic                 o_busy,
   output logic                 o_unexpected,
   output logic                 o_timeout
);

   state_t           state_q, state_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             tx_rd_q, tx_rd_d;        // byte in register owes a response
   logic [LEN_W-1:0] rem_q, rem_d;            // payload bytes still to accept
   logic             shift_rd_q, shift_rd_d;  // current shift requested readback

   logic             cmd_ready;
   logic             data_ready;
   logic             tx_fire;
   logic             cmd_fire;
   logic             data_fire;
   logic [PENDING_W-1:0] pending;

   always_comb begin
      // NOTE: every output of this block gets a default before the case, so
      // no path leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      tx_valid_d = tx_valid_q;
      tx_byte_d  = tx_byte_q;
      tx_rd_d    = tx_rd_q;
      rem_d      = rem_q;
      shift_rd_d = shift_rd_q;

      cmd_ready  = (state_q == IDLE) && !tx_valid_q && (pending <= PENDING_ACCEPT_MAX);
      data_ready = (state_q == SH_DATA) && (!tx_valid_q || i_tx_ready);
      tx_fire    = tx_valid_q && i_tx_ready;
      cmd_fire   = i_cmd_valid && cmd_ready;
      data_fire  = i_data_valid && data_ready;

      // Register empties on a handshake unless reloaded below.
      if (tx_fire) tx_valid_d = 1'b0;

      // The state names the byte currently held (or next to be loaded).
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               if (i_cmd_shift) begin
                  // A zero-length shift is consumed without emitting anything.
                  if (i_cmd_len != '0) begin
                     tx_valid_d = 1'b1;
                     tx_byte_d  = shift_hdr(i_cmd_read, LEN_W'(i_cmd_len));
                     tx_rd_d    = 1'b0;
                     rem_d      = LEN_W'(i_cmd_len);
                     shift_rd_d = i_cmd_read;
                     state_d    = SH_HDR;
                  end
               end else begin
                  tx_valid_d = 1'b1;
                  tx_byte_d  = bb_byte(i_cmd_tms, i_cmd_tdi, i_cmd_led, 1'b0, i_cmd_read);
                  tx_rd_d    = i_cmd_read;
                  state_d    = BB_LOW;
               end
            end
         end

         BB_LOW: begin
            // Rising TCK edge: same pins, no second readback.
            if (tx_fire) begin
               tx_valid_d = 1'b1;
               tx_byte_d  = (tx_byte_q | MASK_TCK) & ~MASK_READ;
               tx_rd_d    = 1'b0;
               state_d    = BB_HIGH;
            end
         end

         BB_HIGH: begin
            if (tx_fire) state_d = IDLE;
         end

         SH_HDR: begin
            if (tx_fire) state_d = SH_DATA;
         end

         SH_DATA: begin
            if (data_fire) begin
               tx_valid_d = 1'b1;
               tx_byte_d  = i_data;
               tx_rd_d    = shift_rd_q;
               rem_d      = rem_q - LEN_W'(1);
               // Last payload byte may still be draining when IDLE is reached;
               // o_cmd_ready stays low until it has gone.
               if (rem_q == LEN_W'(1)) state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         tx_valid_q <= 1'b0;
         tx_byte_q  <= '0;
         tx_rd_q    <= 1'b0;
         rem_q      <= '0;
         shift_rd_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q    <= state_d;
         tx_valid_q <= tx_valid_d;
         tx_byte_q  <= tx_byte_d;
         tx_rd_q    <= tx_rd_d;
         rem_q      <= rem_d;
         shift_rd_q <= shift_rd_d;
      end
   end

   blaster_resp_tracker #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_resp_tracker (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_inc        (tx_fire && tx_rd_q),
      .i_rx_valid   (i_rx_valid),
      .i_rx_byte    (i_rx_byte),
      .o_pending    (pending),
      .o_rd_valid   (o_rd_valid),
      .o_rd_byte    (o_rd_byte),
      .o_unexpected (o_unexpected),
      .o_timeout    (o_timeout)
   );

   assign o_cmd_ready  = cmd_ready;
   assign o_data_ready = data_ready;
   assign o_tx_valid   = tx_valid_q;
   assign o_tx_byte    = tx_byte_q;
   assign o_pending    = pending;
   assign o_busy       = (state_q != IDLE) || tx_valid_q;

endmodule

// File: tb/tb_blaster_host_encoder.sv
// ---------------------------------------------------------------------------
// tb_blaster_host_encoder
// Directed bench for blaster_host_encoder with a 16-cycle response window.
// Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_blaster_host_encoder;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_cmd_valid = 1'b0;
   logic       o_cmd_ready;
   logic       i_cmd_shift = 1'b0;
   logic       i_cmd_read = 1'b0;
   logic       i_cmd_tms = 1'b0;
   logic       i_cmd_tdi = 1'b0;
   logic       i_cmd_led = 1'b0;
   logic [5:0] i_cmd_len = '0;
   logic       i_data_valid = 1'b0;
   logic       o_data_ready;
   logic [7:0] i_data = '0;
   logic       o_tx_valid;
   logic       i_tx_ready = 1'b1;
   logic [7:0] o_tx_byte;
   logic       i_rx_valid = 1'b0;
   logic [7:0] i_rx_byte = '0;
   logic       o_rd_valid;
   logic [7:0] o_rd_byte;
   logic [7:0] o_pending;
   logic       o_busy;
   logic       o_unexpected;
   logic       o_timeout;

   always #5 i_clk = ~i_clk;

   blaster_host_encoder #(
      .TIMEOUT_CYCLES (24'd16)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_shift  (i_cmd_shift),
      .i_cmd_read   (i_cmd_read),
      .i_cmd_tms    (i_cmd_tms),
      .i_cmd_tdi    (i_cmd_tdi),
      .i_cmd_led    (i_cmd_led),
      .i_cmd_len    (i_cmd_len),
      .i_data_valid (i_data_valid),
      .o_data_ready (o_data_ready),
      .i_data       (i_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready),
      .o_tx_byte    (o_tx_byte),
      .i_rx_valid   (i_rx_valid),
      .i_rx_byte    (i_rx_byte),
      .o_rd_valid   (o_rd_valid),
      .o_rd_byte    (o_rd_byte),
      .o_pending    (o_pending),
      .o_busy       (o_busy),
      .o_unexpected (o_unexpected),
      .o_timeout    (o_timeout)
   );

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rd_q[$];
   int         unexp_cnt = 0;
   int         tmo_cnt = 0;
   logic       stall_armed = 1'b0;
   logic [7:0] stall_byte = '0;

   typedef struct {
      logic       tms;
      logic       tdi;
      logic       led;
      logic [7:0] exp_low;
      logic [7:0] exp_high;
   } bb_vec_t;

   bb_vec_t bb_tab[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Output monitor: record accepted TX bytes and readback events, and check
   // that a stalled byte does not change before it is taken.
   always @(negedge i_clk) begin
      if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_byte);
      if (o_rd_valid) rd_q.push_back(o_rd_byte);
      if (o_unexpected) unexp_cnt++;
      if (o_timeout) tmo_cnt++;
      if (stall_armed && o_tx_valid) check("tx_stable_while_stalled", o_tx_byte, stall_byte);
      stall_armed = o_tx_valid && !i_tx_ready;
      stall_byte  = o_tx_byte;
   end

   task automatic send_cmd(input logic sh, input logic rd, input logic tms,
                           input logic tdi, input logic led, input logic [5:0] len);
      int k;
      k = 0;
      @(posedge i_clk); #1;
      i_cmd_shift = sh; i_cmd_read = rd; i_cmd_tms = tms;
      i_cmd_tdi = tdi;  i_cmd_led = led; i_cmd_len = len;
      i_cmd_valid = 1'b1;
      @(negedge i_clk);
      while (!o_cmd_ready && k < 200) begin
         @(negedge i_clk);
         k++;
      end
      check("cmd_ready_wait", {31'd0, o_cmd_ready}, 32'd1);
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b);
      int k;
      k = 0;
      @(posedge i_clk); #1;
      i_data = b;
      i_data_valid = 1'b1;
      @(negedge i_clk);
      while (!o_data_ready && k < 200) begin
         @(negedge i_clk);
         k++;
      end
      check("data_ready_wait", {31'd0, o_data_ready}, 32'd1);
      @(posedge i_clk); #1;
      i_data_valid = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge i_clk); #1;
      i_rx_valid = 1'b1;
      i_rx_byte  = b;
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int k;
      k = 0;
      while (tx_q.size() < n && k < 200) begin
         @(negedge i_clk);
         k++;
      end
      check("tx_byte_count", tx_q.size(), n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int rbase;
      int ubase;
      int n;

      bb_tab[0] = '{tms: 1'b0, tdi: 1'b0, led: 1'b0, exp_low: 8'h00, exp_high: 8'h01};
      bb_tab[1] = '{tms: 1'b1, tdi: 1'b0, led: 1'b0, exp_low: 8'h02, exp_high: 8'h03};
      bb_tab[2] = '{tms: 1'b0, tdi: 1'b1, led: 1'b0, exp_low: 8'h10, exp_high: 8'h11};
      bb_tab[3] = '{tms: 1'b0, tdi: 1'b0, led: 1'b1, exp_low: 8'h20, exp_high: 8'h21};
      bb_tab[4] = '{tms: 1'b1, tdi: 1'b1, led: 1'b1, exp_low: 8'h32, exp_high: 8'h33};

      // Reset values.
      repeat (3) @(negedge i_clk);
      check("rst_tx_valid",   {31'd0, o_tx_valid},   32'd0);
      check("rst_tx_byte",    {24'd0, o_tx_byte},    32'h00);
      check("rst_pending",    {24'd0, o_pending},    32'd0);
      check("rst_busy",       {31'd0, o_busy},       32'd0);
      check("rst_rd_valid",   {31'd0, o_rd_valid},   32'd0);
      check("rst_rd_byte",    {24'd0, o_rd_byte},    32'h00);
      check("rst_unexpected", {31'd0, o_unexpected}, 32'd0);
      check("rst_timeout",    {31'd0, o_timeout},    32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      @(negedge i_clk);
      check("idle_cmd_ready",  {31'd0, o_cmd_ready},  32'd1);
      check("idle_data_ready", {31'd0, o_data_ready}, 32'd0);

      // Bit-bang table, no readback.
      for (int i = 0; i < 5; i++) begin
         base = tx_q.size();
         send_cmd(1'b0, 1'b0, bb_tab[i].tms, bb_tab[i].tdi, bb_tab[i].led, 6'd0);
         wait_tx(base + 2);
         if (tx_q.size() >= base + 2) begin
            check($sformatf("bb%0d_low", i),  {24'd0, tx_q[base]},     {24'd0, bb_tab[i].exp_low});
            check($sformatf("bb%0d_high", i), {24'd0, tx_q[base + 1]}, {24'd0, bb_tab[i].exp_high});
         end
      end
      repeat (2) @(negedge i_clk);
      check("bb_table_busy",    {31'd0, o_busy},    32'd0);
      check("bb_table_pending", {24'd0, o_pending}, 32'd0);

      // Bit-bang with readback, answered by the adapter.
      base  = tx_q.size();
      rbase = rd_q.size();
      ubase = unexp_cnt;
      send_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0);
      wait_tx(base + 2);
      if (tx_q.size() >= base + 2) begin
         check("bbrd_low",  {24'd0, tx_q[base]},     32'h62);
         check("bbrd_high", {24'd0, tx_q[base + 1]}, 32'h23);
      end
      @(negedge i_clk);
      check("bbrd_pending1", {24'd0, o_pending}, 32'd1);
      send_rx(8'h01);
      repeat (2) @(negedge i_clk);
      check("bbrd_rd_count", rd_q.size(), rbase + 1);
      if (rd_q.size() > rbase) check("bbrd_rd_byte", {24'd0, rd_q[rbase]}, 32'h01);
      check("bbrd_pending0", {24'd0, o_pending}, 32'd0);
      check("bbrd_no_unexp", unexp_cnt, ubase);

      // Zero-length shift is swallowed.
      base = tx_q.size();
      send_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      repeat (4) @(negedge i_clk);
      check("len0_no_bytes",  tx_q.size(), base);
      check("len0_busy",      {31'd0, o_busy},      32'd0);
      check("len0_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);

      // Shift without readback.
      base = tx_q.size();
      send_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3);
      send_data(8'hA5);
      send_data(8'h3C);
      send_data(8'hFF);
      wait_tx(base + 4);
      if (tx_q.size() >= base + 4) begin
         check("sh3_hdr", {24'd0, tx_q[base]},     32'h83);
         check("sh3_d0",  {24'd0, tx_q[base + 1]}, 32'hA5);
         check("sh3_d1",  {24'd0, tx_q[base + 2]}, 32'h3C);
         check("sh3_d2",  {24'd0, tx_q[base + 3]}, 32'hFF);
      end
      repeat (2) @(negedge i_clk);
      check("sh3_pending", {24'd0, o_pending}, 32'd0);
      check("sh3_busy",    {31'd0, o_busy},    32'd0);

      // Shift with readback while the TX FIFO alternates ready/stall.
      base  = tx_q.size();
      rbase = rd_q.size();
      fork
         begin
            send_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2);
            send_data(8'h5A);
            send_data(8'hC3);
         end
         begin
            n = 0;
            while (tx_q.size() < base + 3 && n < 100) begin
               @(posedge i_clk); #1;
               i_tx_ready = ~i_tx_ready;
               n++;
            end
         end
      join
      i_tx_ready = 1'b1;
      @(negedge i_clk);
      check("sh2_byte_count", tx_q.size(), base + 3);
      if (tx_q.size() >= base + 3) begin
         check("sh2_hdr", {24'd0, tx_q[base]},     32'hC2);
         check("sh2_d0",  {24'd0, tx_q[base + 1]}, 32'h5A);
         check("sh2_d1",  {24'd0, tx_q[base + 2]}, 32'hC3);
      end
      check("sh2_pending2", {24'd0, o_pending}, 32'd2);
      send_rx(8'h11);
      send_rx(8'h22);
      repeat (2) @(negedge i_clk);
      check("sh2_rd_count", rd_q.size(), rbase + 2);
      if (rd_q.size() >= rbase + 2) begin
         check("sh2_rd0", {24'd0, rd_q[rbase]},     32'h11);
         check("sh2_rd1", {24'd0, rd_q[rbase + 1]}, 32'h22);
      end
      check("sh2_pending0", {24'd0, o_pending}, 32'd0);

      // Stray response byte.
      rbase = rd_q.size();
      ubase = unexp_cnt;
      send_rx(8'h77);
      repeat (3) @(negedge i_clk);
      check("stray_unexp_pulses", unexp_cnt, ubase + 1);
      check("stray_no_rd",        rd_q.size(), rbase);
      check("stray_pending",      {24'd0, o_pending}, 32'd0);

      // Unanswered read times out after 16 cycles.
      base = tx_q.size();
      send_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      n = 0;
      while (o_pending != 8'd1 && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check("tmo_pending1", {24'd0, o_pending}, 32'd1);
      n = 0;
      while (!o_timeout && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      check("tmo_latency",     n, 16);
      check("tmo_pending0",    {24'd0, o_pending}, 32'd0);
      @(negedge i_clk);
      check("tmo_one_cycle",   {31'd0, o_timeout}, 32'd0);
      check("tmo_pulse_count", tmo_cnt, 1);
      if (tx_q.size() >= base + 2) begin
         check("tmo_low",  {24'd0, tx_q[base]},     32'h40);
         check("tmo_high", {24'd0, tx_q[base + 1]}, 32'h01);
      end

      // Reset in the middle of a 5-byte read shift.
      base = tx_q.size();
      send_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5);
      send_data(8'h81);
      repeat (2) @(negedge i_clk);
      check("mid_pending1", {24'd0, o_pending}, 32'd1);
      if (tx_q.size() >= base + 2) begin
         check("mid_hdr", {24'd0, tx_q[base]},     32'hC5);
         check("mid_d0",  {24'd0, tx_q[base + 1]}, 32'h81);
      end
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      @(negedge i_clk);
      check("mid_rst_tx_valid",   {31'd0, o_tx_valid},   32'd0);
      check("mid_rst_pending",    {24'd0, o_pending},    32'd0);
      check("mid_rst_busy",       {31'd0, o_busy},       32'd0);
      check("mid_rst_data_ready", {31'd0, o_data_ready}, 32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      base = tx_q.size();
      send_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
      wait_tx(base + 2);
      if (tx_q.size() >= base + 2) begin
         check("post_rst_low",  {24'd0, tx_q[base]},     32'h30);
         check("post_rst_high", {24'd0, tx_q[base + 1]}, 32'h31);
      end
      repeat (2) @(negedge i_clk);
      check("post_rst_busy",    {31'd0, o_busy},    32'd0);
      check("post_rst_pending", {24'd0, o_pending}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/blaster_host_encoder.md
BLASTER_HOST_ENCODER -- requirements
Module: blaster_host_encoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1_000_000: response-timeout window in i_clk cycles.
REQ-002 SHALL have port i_clk, input, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports i_cmd_valid / o_cmd_ready, input / output, 1 / 1: command handshake.
REQ-005 SHALL have ports i_cmd_shift / i_cmd_read, input, 1 / 1: 1 = shift command / 1 = request readback.
REQ-006 SHALL have ports i_cmd_tms, i_cmd_tdi, i_cmd_led, input, 1 each: pin levels for a bit-bang step.
REQ-007 SHALL have port i_cmd_len, input, 6: shift byte count, 1..63.
REQ-008 SHALL have ports i_data_valid / o_data_ready / i_data, in / out / in, 1 / 1 / 8: shift payload bytes.
REQ-009 SHALL have ports o_tx_valid / i_tx_ready / o_tx_byte, out / in / out, 1 / 1 / 8: encoded byte stream to the UART TX FIFO.
REQ-010 SHALL have ports i_rx_valid / i_rx_byte, input, 1 / 8: response bytes from the UART RX; no backpressure.
REQ-011 SHALL have ports o_rd_valid / o_rd_byte, output, 1 / 8: readback bytes, one-cycle strobe.
REQ-012 SHALL have ports o_pending (out, 8), o_busy (out, 1), o_unexpected (out, 1), o_timeout (out, 1): outstanding responses, not IDLE, stray-byte pulse, timeout pulse.

Function
REQ-013 Byte masks SHALL be: TCK 0x01, TMS 0x02, TDI 0x10, LED 0x20, READ 0x40, SHIFT 0x80.
REQ-014 FSM states SHALL be IDLE, BB_LOW, BB_HIGH, SH_HDR, SH_DATA.
REQ-015 o_cmd_ready SHALL be 1 only in IDLE with o_tx_valid=0 and o_pending <= 192.
REQ-016 A bit-bang command accepted SHALL go to BB_LOW: byte = TMS/TDI/LED from command, TCK=0, READ=i_cmd_read.
REQ-017 BB_LOW, after handshake, SHALL go to BB_HIGH: same byte with TCK=1 and READ=0; after handshake, to IDLE.
REQ-018 A shift command with len 1..63 SHALL go to SH_HDR: byte = 0x80 | (READ if i_cmd_read) | len.
REQ-019 A shift command with len 0 SHALL be accepted and discarded: no bytes, stay IDLE.
REQ-020 SH_DATA SHALL forward exactly len payload bytes unchanged, then return to IDLE.
REQ-021 o_data_ready SHALL be 1 only in SH_DATA with the output register empty or draining (o_tx_valid=0 or i_tx_ready=1).
REQ-022 o_tx_byte SHALL appear the cycle after command/data acceptance and SHALL hold stable while o_tx_valid=1 and i_tx_ready=0.
REQ-023 o_pending SHALL increment when a readback-generating byte handshakes (BB_LOW byte with READ; each shift payload byte when read set).
REQ-024 o_pending SHALL decrement on i_rx_valid when nonzero; simultaneous increment and decrement SHALL leave it unchanged.
REQ-025 For i_rx_valid with o_pending nonzero, the next cycle SHALL give o_rd_valid=1, o_rd_byte=i_rx_byte.
REQ-026 For i_rx_valid with o_pending=0 and no simultaneous increment, the next cycle SHALL give o_unexpected=1 for one cycle; the byte SHALL be dropped.
REQ-027 Timeout counter SHALL run while o_pending nonzero and clear on any i_rx_valid or when o_pending=0.
REQ-028 At TIMEOUT_CYCLES the block SHALL pulse o_timeout for one cycle and clear o_pending to 0.
REQ-029 Timeout SHALL NOT abort the FSM or the output stream.
REQ-030 o_busy SHALL be 1 whenever state is not IDLE or o_tx_valid=1.

Reset
REQ-031 On i_reset: state=IDLE, o_tx_valid=0, o_tx_byte=0, o_pending=0, timeout counter=0, o_rd_valid=0, o_rd_byte=0, o_unexpected=0, o_timeout=0.
REQ-032 Reset mid-command SHALL discard the partial command; the next command after release SHALL start cleanly from IDLE.

Structure
REQ-033 Package blaster_pkg SHALL hold the byte masks, the FSM state enum, and MAX_SHIFT_LEN=63.
REQ-034 Pending counter, timeout and unexpected detection SHALL form sub-module blaster_resp_tracker.

Verification
REQ-035 Bit-bang tms=1, tdi=0, led=1, read=1, i_tx_ready=1 -> bytes 0x62 then 0x23; o_pending 1; rx 0x01 -> o_rd_byte 0x01, o_pending 0.
REQ-036 Shift len=3, read=0, data A5 3C FF -> bytes 0x83 A5 3C FF; o_pending stays 0; back to IDLE.
REQ-037 Shift len=2, read=1, i_tx_ready toggling 1/0 -> bytes 0xC2 d0 d1 with no loss or duplication; o_tx_byte stable while stalled; o_pending 2.
REQ-038 Rx byte while o_pending=0 -> one-cycle o_unexpected, no o_rd_valid.
REQ-039 TIMEOUT_CYCLES=16, one pending read, no response -> o_timeout pulse after 16 cycles, o_pending 0.
REQ-040 Reset asserted in SH_DATA after 1 of 5 payload bytes -> o_tx_valid=0, o_pending=0, IDLE; next command encoded correctly.
